// File: rtl/regfile_pkg.sv
// Shared defaults and types for the 2R1W register file with link port.
// Optional write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_LINK_REG = 31;
  localparam int LINK_OFFSET = 4;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

endpackage

// File: rtl/regfile_clear_ctl.sv
// Post-reset clear sequencer: sweeps every entry to zero, then enters RUN.
// Drives the array clear port and the busy flag.
module regfile_clear_ctl
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr,
  output logic              o_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  rf_state_t         r_state;
  rf_state_t         w_state_nxt;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic [ADDR_W-1:0] w_clr_ptr_nxt;

  // State and sweep pointer; reset restarts the sweep from entry 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  // Next state: one entry cleared per cycle, RUN after the last one.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    o_clr_we      = 1'b0;
    o_busy        = 1'b0;
    unique case (r_state)
      CLEAR: begin
        o_clr_we      = 1'b1;
        o_busy        = 1'b1;
        w_clr_ptr_nxt = r_clr_ptr + 1'b1;
        if (r_clr_ptr == ADDR_W'(DEPTH - 1)) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_state_nxt = RUN;
      end
      default: begin
        w_state_nxt = CLEAR;
      end
    endcase
  end

  assign o_clr_addr = r_clr_ptr;

endmodule

// File: rtl/regfile_2r1w_link.sv
// Decode-stage register file: 2 async reads, 1 sync write, 1 link write.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_2r1w_link
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int LINK_REG = RF_LINK_REG,
  parameter int ZERO_R0  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              link_en,
  input  logic [DATA_W-1:0] link_pc,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [27:0]       jump_tgt,
  output logic              busy
);

  localparam int          DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_link_we;
  logic              w_wr_we;
  logic [DATA_W-1:0] w_link_val;
  logic              w_wr_r0;

  regfile_clear_ctl #(
    .ADDR_W (ADDR_W)
  ) u_clear_ctl (
    .clk        (clk),
    .rst        (rst),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr),
    .o_busy     (w_busy)
  );

  assign w_link_val = link_pc + DATA_W'(LINK_OFFSET);
  assign w_wr_r0    = (ZERO_R0 != 0) && (wr_addr == '0);
  assign w_link_we  = !w_busy && link_en;
  // Link wins a collision on LINK_REG, so the port write is suppressed.
  assign w_wr_we    = !w_busy && wr_en && !w_wr_r0 &&
                      !(w_link_we && (wr_addr == LINK_IDX));

  // Array update: clear sweep owns the array; otherwise link and port.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else begin
      if (w_link_we) begin
        r_mem[LINK_IDX] <= w_link_val;
      end
      if (w_wr_we) begin
        r_mem[wr_addr] <= wr_data;
      end
    end
  end

  // Read port A: array value, optional forwarding, zero masking.
  always_comb begin
    rd_data_a = r_mem[rd_addr_a];
`ifdef REGFILE_BYPASS_EN
    if (w_wr_we && (rd_addr_a == wr_addr)) begin
      rd_data_a = wr_data;
    end
    if (w_link_we && (rd_addr_a == LINK_IDX)) begin
      rd_data_a = w_link_val;
    end
`endif
    if (w_busy || ((ZERO_R0 != 0) && (rd_addr_a == '0))) begin
      rd_data_a = '0;
    end
  end

  // Read port B: same rules as port A.
  always_comb begin
    rd_data_b = r_mem[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
    if (w_wr_we && (rd_addr_b == wr_addr)) begin
      rd_data_b = wr_data;
    end
    if (w_link_we && (rd_addr_b == LINK_IDX)) begin
      rd_data_b = w_link_val;
    end
`endif
    if (w_busy || ((ZERO_R0 != 0) && (rd_addr_b == '0))) begin
      rd_data_b = '0;
    end
  end

  assign jump_tgt = {rd_data_a[25:0], 2'b00};
  assign busy     = w_busy;

endmodule

// File: tb/tb_regfile_2r1w_link.sv
// Scoreboard bench for regfile_2r1w_link: directed vectors,
// expectations queued by stimulus, compared by a negedge monitor.
module tb_regfile_2r1w_link;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        link_en;
  logic [31:0] link_pc;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic [27:0] jump_tgt;
  logic        busy;

  regfile_2r1w_link dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .link_en   (link_en),
    .link_pc   (link_pc),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .jump_tgt  (jump_tgt),
    .busy      (busy)
  );

  localparam int K_RDA  = 0;
  localparam int K_RDB  = 1;
  localparam int K_JT   = 2;
  localparam int K_BUSY = 3;
  localparam int K_BCNT = 4;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } sb_t;

  sb_t  q[$];
  logic chk_req;
  int   checks;
  int   errors;
  int   bcnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: counts busy cycles, then pops and compares queued items.
  always @(negedge clk) begin
    sb_t         it;
    logic [31:0] act;
    if (rst) bcnt = 0;
    else if (busy) bcnt = bcnt + 1;
    if (chk_req) begin
      while (q.size() > 0) begin
        it = q.pop_front();
        case (it.kind)
          K_RDA:   act = rd_data_a;
          K_RDB:   act = rd_data_b;
          K_JT:    act = {4'h0, jump_tgt};
          K_BUSY:  act = {31'h0, busy};
          default: act = bcnt;
        endcase
        checks = checks + 1;
        if (act !== it.exp) begin
          errors = errors + 1;
          $display("FAIL %s: got %h want %h", it.name, act, it.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string n, input int k, input logic [31:0] e);
    sb_t it;
    it.name = n;
    it.kind = k;
    it.exp  = e;
    q.push_back(it);
  endtask

  task automatic check_now();
    chk_req = 1'b1;
    @(negedge clk);
    #1;
    chk_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    if (busy) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL wait_idle: busy still %b after %0d cycles", busy, n);
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic do_link(input logic [31:0] pc);
    link_en = 1'b1;
    link_pc = pc;
    tick();
    link_en = 1'b0;
  endtask

  task automatic rd_a(input string n, input logic [4:0] a, input logic [31:0] e);
    rd_addr_a = a;
    push(n, K_RDA, e);
    check_now();
  endtask

  task automatic rd_b(input string n, input logic [4:0] a, input logic [31:0] e);
    rd_addr_b = a;
    push(n, K_RDB, e);
    check_now();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t exceeded limit %0d", $time, 1_000_000);
    $fatal(1);
  end

  initial begin
    checks    = 0;
    errors    = 0;
    bcnt      = 0;
    chk_req   = 1'b0;
    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    link_en   = 1'b0;
    link_pc   = '0;
    rd_addr_a = '0;
    rd_addr_b = '0;

    // Power-up sweep
    repeat (2) tick();
    push("busy_in_reset", K_BUSY, 32'd1);
    push("rda_in_reset", K_RDA, 32'd0);
    check_now();
    tick();
    rst = 1'b0;
    wait_idle();
    push("busy_cnt_first", K_BCNT, 32'd32);
    push("busy_low", K_BUSY, 32'd0);
    check_now();

    // Preload garbage, then reset from RUN
    for (int i = 1; i < 32; i++) begin
      do_write(5'(i), 32'hA000_0000 | i);
    end
    rd_a("garbage_r17", 5'd17, 32'hA000_0011);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_idle();
    push("busy_cnt_restart", K_BCNT, 32'd32);
    check_now();
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = 5'(i);
      rd_addr_b = 5'(31 - i);
      push($sformatf("clr_a_r%0d", i), K_RDA, 32'd0);
      push($sformatf("clr_b_r%0d", 31 - i), K_RDB, 32'd0);
      check_now();
    end

    // Write / read
    do_write(5'd5, 32'hDEAD_BEEF);
    rd_a("wr_r5", 5'd5, 32'hDEAD_BEEF);
    do_write(5'd0, 32'h0000_0001);
    rd_a("wr_r0_a", 5'd0, 32'h0);
    rd_b("wr_r0_b", 5'd0, 32'h0);
    rd_addr_a = 5'd5;
    rd_addr_b = 5'd5;
    push("same_a_r5", K_RDA, 32'hDEAD_BEEF);
    push("same_b_r5", K_RDB, 32'hDEAD_BEEF);
    check_now();

    // Link
    do_link(32'h0040_0020);
    rd_addr_a = 5'd31;
    push("link_r31", K_RDA, 32'h0040_0024);
    push("link_jt", K_JT, 32'h0100_0090);
    check_now();
    do_link(32'hFFFF_FFFC);
    push("link_wrap", K_RDA, 32'h0);
    push("link_wrap_jt", K_JT, 32'h0);
    check_now();
    do_write(5'd3, 32'hFC00_0003);
    rd_addr_a = 5'd3;
    push("jt_trunc", K_JT, 32'h0000_000C);
    check_now();

    // Collision
    do_write(5'd31, 32'h0000_0055);
    wr_en   = 1'b1;
    wr_addr = 5'd31;
    wr_data = 32'h0000_1111;
    link_en = 1'b1;
    link_pc = 32'h0000_0100;
    tick();
    wr_en   = 1'b0;
    link_en = 1'b0;
    rd_a("coll_r31", 5'd31, 32'h0000_0104);
    do_write(5'd31, 32'h0000_0055);
    wr_en   = 1'b1;
    wr_addr = 5'd7;
    wr_data = 32'h0000_1111;
    link_en = 1'b1;
    link_pc = 32'h0000_0100;
    tick();
    wr_en   = 1'b0;
    link_en = 1'b0;
    rd_addr_a = 5'd7;
    rd_addr_b = 5'd31;
    push("both_r7", K_RDA, 32'h0000_1111);
    push("both_r31", K_RDB, 32'h0000_0104);
    check_now();

    // Same-cycle read of a committing write
    do_write(5'd9, 32'h1234_5678);
    wr_en     = 1'b1;
    wr_addr   = 5'd9;
    wr_data   = 32'hA5A5_A5A5;
    rd_addr_b = 5'd9;
`ifdef REGFILE_BYPASS_EN
    push("byp_r9", K_RDB, 32'hA5A5_A5A5);
`else
    push("byp_r9", K_RDB, 32'h1234_5678);
`endif
    check_now();
    tick();
    wr_en = 1'b0;
    rd_b("after_r9", 5'd9, 32'hA5A5_A5A5);
    wr_en     = 1'b1;
    wr_addr   = 5'd0;
    wr_data   = 32'h0000_00FF;
    rd_addr_a = 5'd0;
    push("byp_r0", K_RDA, 32'h0);
    check_now();
    tick();
    wr_en     = 1'b0;
    wr_en     = 1'b1;
    wr_addr   = 5'd31;
    wr_data   = 32'h0000_0007;
    link_en   = 1'b1;
    link_pc   = 32'h0000_0200;
    rd_addr_a = 5'd31;
`ifdef REGFILE_BYPASS_EN
    push("byp_link", K_RDA, 32'h0000_0204);
`else
    push("byp_link", K_RDA, 32'h0000_0104);
`endif
    check_now();
    tick();
    wr_en   = 1'b0;
    link_en = 1'b0;
    rd_a("after_link", 5'd31, 32'h0000_0204);

    // Reset mid-sweep with writes attempted while busy
    do_write(5'd12, 32'h0000_BEEF);
    rd_a("pre_r12", 5'd12, 32'h0000_BEEF);
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 5'd12;
    wr_data = 32'h0000_CAFE;
    link_en = 1'b1;
    link_pc = 32'h0000_0300;
    repeat (2) tick();
    rd_addr_a = 5'd31;
    push("busy_mid", K_BUSY, 32'd1);
    push("rd_busy_r31", K_RDA, 32'h0);
    check_now();
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_idle();
    wr_en   = 1'b0;
    link_en = 1'b0;
    push("busy_cnt_mid", K_BCNT, 32'd32);
    check_now();
    rd_addr_a = 5'd12;
    rd_addr_b = 5'd31;
    push("drop_r12", K_RDA, 32'h0);
    push("drop_r31", K_RDB, 32'h0);
    check_now();

    if (q.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL queue_drain: %0d left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
